// File: rtl/icache_sa2_wb.sv
// 2-way set-associative, write-back, write-allocate cache with one word per line.
// The CPU side uses a valid/ready request with a one-cycle response pulse; the memory side uses valid/ready.
`timescale 1ns/1ps

module icache_sa2_wb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_req_ready,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_data,
    output logic                  mem_req_valid,
    output logic                  mem_req_wr,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDR_WIDTH - INDEX_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_WIDTH-3:0] r_word_addr;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [SETS-1:0]       r_valid [2];
    logic [SETS-1:0]       r_dirty [2];
    logic [SETS-1:0]       r_lru;
    logic [TAG_W-1:0]      r_tag   [2][SETS];
    logic [DATA_WIDTH-1:0] r_data  [2][SETS];

    logic                  r_victim;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic [INDEX_W-1:0]    w_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic                  w_hit_way;
    logic                  w_miss_victim;
    logic                  w_unused_offset;

    // The byte offset never selects anything: lines are one word wide.
    assign w_unused_offset = ^cpu_req_addr[1:0];

    assign w_idx     = r_word_addr[INDEX_W-1:0];
    assign w_req_tag = r_word_addr[ADDR_WIDTH-3:INDEX_W];
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_req_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_req_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = w_hit1;

    // Fill an empty way first (way0 before way1); only a full set consults LRU.
    assign w_miss_victim = !r_valid[0][w_idx] ? 1'b0 :
                           !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

    assign cpu_resp_valid = r_resp_valid;
    assign cpu_resp_data  = r_resp_data;

    // NOTE: state-holding blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        cpu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (r_state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    w_next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    w_next_state = S_IDLE;
                end else if (r_valid[w_miss_victim][w_idx] && r_dirty[w_miss_victim][w_idx]) begin
                    w_next_state = S_WRITEBACK;
                end else begin
                    w_next_state = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_wr    = 1'b1;
                mem_req_addr  = {r_tag[r_victim][w_idx], w_idx, 2'b00};
                mem_req_wdata = r_data[r_victim][w_idx];
                if (mem_req_ready) begin
                    w_next_state = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {w_req_tag, w_idx, 2'b00};
                if (mem_req_ready) begin
                    w_next_state = S_COMPARE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_addr  <= '0;
            r_wr         <= 1'b0;
            r_wdata      <= '0;
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_dirty[0]   <= '0;
            r_dirty[1]   <= '0;
            r_lru        <= '0;
            r_victim     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        r_word_addr <= cpu_req_addr[ADDR_WIDTH-1:2];
                        r_wr        <= cpu_req_wr;
                        r_wdata     <= cpu_req_wdata;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_lru[w_idx] <= ~w_hit_way;
                        if (r_wr) begin
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                            r_resp_data               <= r_wdata;
                        end else begin
                            r_resp_data <= r_data[w_hit_way][w_idx];
                        end
                    end else begin
                        r_victim <= w_miss_victim;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_req_ready) begin
                        r_dirty[r_victim][w_idx] <= 1'b0;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_req_ready) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/data arrays carry no reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (r_state == S_COMPARE && w_hit && r_wr) begin
            r_data[w_hit_way][w_idx] <= r_wdata;
        end
        if (r_state == S_ALLOCATE && mem_req_ready) begin
            r_tag[r_victim][w_idx]  <= w_req_tag;
            r_data[r_victim][w_idx] <= mem_resp_data;
        end
    end

endmodule
